// File: rtl/xf_load_sequencer.sv
// Turns a CP "load XF registers" header into one address-incrementing XF write per GX FIFO word.
// Optional macro XF_LOAD_RANGE_CHECK_EN drops writes at addresses >= 0x1058 and raises sticky RangeErr.
module xf_load_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        HdrValid,
    input  logic [31:0] HdrData,
    output logic        HdrReady,
    output logic        GXFIFORead,
    input  logic        GXFIFOValid,
    input  logic [31:0] GXFIFOData,
    output logic [15:0] XFAddr,
    output logic [31:0] XFWriteData,
    output logic        XFWrite,
    input  logic        XFReady,
    output logic        Busy,
    output logic        Done,
    output logic        RangeErr,
    output logic [1:0]  state_dbg
);
    // Every channel transfers on a cycle where its valid and ready are both high (HdrValid/HdrReady,
    // GXFIFOValid/GXFIFORead, XFWrite/XFReady); XFWrite, XFAddr and XFWriteData hold until XFReady.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] addr;
    logic [16:0] remain;
    logic        slot_free;
    logic        pop;
    logic        write_ok;

    assign slot_free  = !XFWrite || XFReady;
    assign GXFIFORead = (state == LOAD) && slot_free;
    assign pop        = GXFIFORead && GXFIFOValid;
    assign HdrReady   = (state == IDLE);
    assign Busy       = (state != IDLE);
    assign state_dbg  = state;

`ifdef XF_LOAD_RANGE_CHECK_EN
    // Addresses from 0x1058 upward are unmapped XF space: the word is consumed but never written.
    assign write_ok = (addr < 16'h1058);

    always_ff @(posedge clk) begin
        if (reset) begin
            RangeErr <= 1'b0;
        end else if (pop && !write_ok) begin
            RangeErr <= 1'b1;
        end
    end
`else
    assign write_ok = 1'b1;
    assign RangeErr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= 16'd0;
            remain      <= 17'd0;
            XFAddr      <= 16'd0;
            XFWriteData <= 32'd0;
            XFWrite     <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (XFWrite && XFReady) begin
                XFWrite <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (HdrValid) begin
                        addr   <= HdrData[15:0];
                        remain <= {1'b0, HdrData[31:16]} + 17'd1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // A pop only happens when the slot is free or draining, so reloading here is safe.
                    if (pop) begin
                        if (write_ok) begin
                            XFWrite     <= 1'b1;
                            XFAddr      <= addr;
                            XFWriteData <= GXFIFOData;
                        end
                        addr   <= addr + 16'd1;
                        remain <= remain - 17'd1;
                        if (remain == 17'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (slot_free) begin
                        state <= IDLE;
                        Done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xf_load_sequencer.sv
// Directed bench for xf_load_sequencer: a load-level model (per-header word/address lists) checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_xf_load_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        HdrValid;
    logic [31:0] HdrData;
    logic        HdrReady;
    logic        GXFIFORead;
    logic        GXFIFOValid;
    logic [31:0] GXFIFOData;
    logic [15:0] XFAddr;
    logic [31:0] XFWriteData;
    logic        XFWrite;
    logic        XFReady;
    logic        Busy;
    logic        Done;
    logic        RangeErr;
    logic [1:0]  state_dbg;

    xf_load_sequencer dut (
        .clk(clk), .reset(reset),
        .HdrValid(HdrValid), .HdrData(HdrData), .HdrReady(HdrReady),
        .GXFIFORead(GXFIFORead), .GXFIFOValid(GXFIFOValid), .GXFIFOData(GXFIFOData),
        .XFAddr(XFAddr), .XFWriteData(XFWriteData), .XFWrite(XFWrite), .XFReady(XFReady),
        .Busy(Busy), .Done(Done), .RangeErr(RangeErr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002, WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004, WE = 32'hE000_0005, WF = 32'hF000_0006;
    localparam logic [31:0] WP = 32'h1234_5678, WG = 32'h0000_00C7, WH = 32'h0000_00C8;
    localparam logic [31:0] WM = 32'h5A5A_0001, WN = 32'h5A5A_0002;

    int checks = 0;
    int errors = 0;

    // Bench-side GX FIFO: the driver fills it, the compare process consumes it on observed pops.
    logic [31:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic        valid_gate = 1'b1;
    logic        ready_val = 1'b1;
    logic        hdr_pend = 1'b0;
    logic [31:0] hdr_word = 32'd0;
    int          hdr_target = 0;

    // Load-level model state.
    logic        busy_m = 1'b0;
    logic        done_m = 1'b0;
    logic        range_m = 1'b0;
    logic [15:0] addr_m = 16'd0;
    int          pops_left = 0;
    logic [47:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr = 16'd0;
    logic [31:0] prev_data = 32'd0;
    logic        rst_prev = 1'b0;

    int cyc = 0, hdr_acc = 0, done_n = 0, busy_n = 0, wr_n = 0, acc_cyc = 0, done_cyc = 0;
    logic [15:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cyc  [0:63];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Compare process: checks DUT outputs against the load model on every cycle.
    always @(negedge clk) begin
        logic        popped;
        logic        rd_exp;
        logic        busy_nx;
        logic        done_nx;
        logic        range_nx;
        logic [47:0] e;
        logic [31:0] w;
        if (reset) begin
            if (rst_prev) begin
                chk("rst_hdr_ready", HdrReady, 1);
                chk("rst_busy", Busy, 0);
                chk("rst_done", Done, 0);
                chk("rst_range_err", RangeErr, 0);
                chk("rst_fifo_read", GXFIFORead, 0);
                chk("rst_xf_write", XFWrite, 0);
                chk("rst_xf_addr", XFAddr, 0);
                chk("rst_xf_data", XFWriteData, 0);
            end
            busy_m = 1'b0;
            done_m = 1'b0;
            range_m = 1'b0;
            pops_left = 0;
            exp_q.delete();
            rd_ptr = wr_ptr;
            prev_stall = 1'b0;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            chk("busy", Busy, busy_m);
            chk("hdr_ready", HdrReady, !busy_m);
            chk("done", Done, done_m);
            chk("range_err", RangeErr, range_m);
            rd_exp = busy_m && (pops_left > 0) && (!XFWrite || XFReady);
            chk("fifo_read", GXFIFORead, rd_exp);
            if (!busy_m) chk("write_when_idle", XFWrite, 0);
            if (prev_stall) begin
                chk("hold_write", XFWrite, 1);
                chk("hold_addr", XFAddr, prev_addr);
                chk("hold_data", XFWriteData, prev_data);
            end
            busy_nx = busy_m;
            done_nx = 1'b0;
            range_nx = range_m;
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (XFWrite && XFReady) begin
                chk("write_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", XFAddr, e[47:32]);
                    chk("write_data", XFWriteData, e[31:0]);
                end
                wr_addr[6'(wr_n)] = XFAddr;
                wr_data[6'(wr_n)] = XFWriteData;
                wr_cyc[6'(wr_n)] = cyc;
                wr_n++;
            end
            popped = GXFIFORead && GXFIFOValid;
            if (popped) begin
                chk("pop_within_load", (pops_left > 0), 1);
                w = fifo_mem[6'(rd_ptr)];
                rd_ptr++;
`ifdef XF_LOAD_RANGE_CHECK_EN
                if (addr_m >= 16'h1058) range_nx = 1'b1;
                else exp_q.push_back({addr_m, w});
`else
                exp_q.push_back({addr_m, w});
`endif
                addr_m = addr_m + 16'd1;
                if (pops_left > 0) pops_left--;
            end
            // A load ends once every word is popped and written, and not in the cycle of its last pop.
            if (busy_m && pops_left == 0 && exp_q.size() == 0 && !popped) begin
                busy_nx = 1'b0;
                done_nx = 1'b1;
            end
            if (HdrValid && !busy_m) begin
                addr_m = HdrData[15:0];
                pops_left = int'(HdrData[31:16]) + 1;
                busy_nx = 1'b1;
                hdr_acc++;
                acc_cyc = cyc;
            end
            prev_stall = XFWrite && !XFReady;
            prev_addr = XFAddr;
            prev_data = XFWriteData;
            busy_m = busy_nx;
            done_m = done_nx;
            range_m = range_nx;
            cyc++;
        end
    end

    task automatic drive();
        if (hdr_acc >= hdr_target) hdr_pend = 1'b0;
        HdrValid = hdr_pend;
        HdrData = hdr_word;
        GXFIFOValid = valid_gate && (rd_ptr != wr_ptr);
        GXFIFOData = fifo_mem[6'(rd_ptr)];
        XFReady = ready_val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[6'(wr_ptr)] = w;
        wr_ptr++;
    endtask

    task automatic send_hdr(input logic [31:0] h);
        hdr_word = h;
        hdr_pend = 1'b1;
        hdr_target = hdr_acc + 1;
        drive();
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_n < target && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", (done_n >= target), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        int d0;
        int bz;
        int rc;
        logic [3:0] pat;
        reset = 1'b1;
        HdrValid = 1'b0;
        HdrData = 32'd0;
        GXFIFOValid = 1'b0;
        GXFIFOData = 32'd0;
        XFReady = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("idle_hdr_ready", HdrReady, 1);
        chk("idle_busy", Busy, 0);
        chk("idle_xf_write", XFWrite, 0);

        // Three words at 0x1000, full throughput.
        push(WA); push(WB); push(WC);
        b = wr_n; d0 = done_n; bz = busy_n;
        send_hdr(32'h0002_1000);
        wait_done(d0 + 1, 40);
        tick();
        chk("t1_count", wr_n - b, 3);
        chk("t1_addr0", wr_addr[6'(b)], 16'h1000);
        chk("t1_addr1", wr_addr[6'(b + 1)], 16'h1001);
        chk("t1_addr2", wr_addr[6'(b + 2)], 16'h1002);
        chk("t1_data0", wr_data[6'(b)], WA);
        chk("t1_data2", wr_data[6'(b + 2)], WC);
        chk("t1_consecutive", wr_cyc[6'(b + 2)] - wr_cyc[6'(b)], 2);
        chk("t1_done_after_last", done_cyc - wr_cyc[6'(b + 2)], 1);
        chk("t1_done_latency", done_cyc - acc_cyc, 5);
        chk("t1_busy_cycles", busy_n - bz, 4);
        chk("t1_done_pulses", done_n - d0, 1);

        // One word with XF stalled for five cycles.
        push(WD);
        b = wr_n; d0 = done_n;
        ready_val = 1'b0;
        send_hdr(32'h0000_0500);
        repeat (4) tick();
        chk("t2_stall_write", XFWrite, 1);
        chk("t2_stall_addr", XFAddr, 16'h0500);
        chk("t2_stall_data", XFWriteData, WD);
        chk("t2_stall_no_pop", GXFIFORead, 0);
        repeat (2) tick();
        ready_val = 1'b1;
        tick();
        rc = cyc;
        wait_done(d0 + 1, 20);
        chk("t2_count", wr_n - b, 1);
        chk("t2_first_ready", wr_cyc[6'(b)], rc);

        // Address wrap, with a second header offered while busy.
        push(WE); push(WF); push(WP);
        b = wr_n; d0 = done_n;
        send_hdr(32'h0001_FFFF);
        tick();
        send_hdr(32'h0000_0040);
        wait_done(d0 + 2, 40);
        chk("t3_count", wr_n - b, 3);
        chk("t3_addr_ffff", wr_addr[6'(b)], 16'hFFFF);
        chk("t3_addr_wrap", wr_addr[6'(b + 1)], 16'h0000);
        chk("t3_addr_next", wr_addr[6'(b + 2)], 16'h0040);
        chk("t3_data_wrap", wr_data[6'(b + 1)], WF);
        chk("t3_data_next", wr_data[6'(b + 2)], WP);
        chk("t3_accept_in_done", acc_cyc - wr_cyc[6'(b + 1)], 1);

        // FIFO valid toggling 1,0,0,1 across a 2-word load.
        push(WG); push(WH);
        b = wr_n; d0 = done_n;
        pat = 4'b1001;
        send_hdr(32'h0001_0020);
        for (int i = 3; i >= 0; i--) begin
            valid_gate = pat[i];
            tick();
        end
        valid_gate = 1'b1;
        wait_done(d0 + 1, 20);
        tick();
        chk("t4_count", wr_n - b, 2);
        chk("t4_addr0", wr_addr[6'(b)], 16'h0020);
        chk("t4_addr1", wr_addr[6'(b + 1)], 16'h0021);
        chk("t4_data0", wr_data[6'(b)], WG);
        chk("t4_data1", wr_data[6'(b + 1)], WH);
        chk("t4_done_after_last", done_cyc - wr_cyc[6'(b + 1)], 1);

        // Reset in the middle of a 4-word load.
        push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333); push(32'h4444_4444);
        send_hdr(32'h0003_0100);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("t5_write_cleared", XFWrite, 0);
        chk("t5_no_pop", GXFIFORead, 0);
        chk("t5_hdr_ready", HdrReady, 1);
        chk("t5_busy", Busy, 0);
        chk("t5_addr", XFAddr, 0);
        tick();
        reset = 1'b0;
        b = wr_n;
        repeat (5) tick();
        chk("t5_no_writes", wr_n - b, 0);

        // Boundary of mapped XF space.
        push(WM); push(WN);
        b = wr_n; d0 = done_n;
        send_hdr(32'h0001_1057);
        wait_done(d0 + 1, 20);
        tick();
        chk("t6_addr_first", wr_addr[6'(b)], 16'h1057);
        chk("t6_data_first", wr_data[6'(b)], WM);
`ifdef XF_LOAD_RANGE_CHECK_EN
        chk("t6_count", wr_n - b, 1);
        chk("t6_range_err", RangeErr, 1);
`else
        chk("t6_count", wr_n - b, 2);
        chk("t6_addr_second", wr_addr[6'(b + 1)], 16'h1058);
        chk("t6_range_err", RangeErr, 0);
`endif
        chk("t6_fifo_drained", (rd_ptr == wr_ptr), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
